trail_blitter: RTL

TRAIL_BLITTER -- requirements
Module: trail_blitter

---
 rtl/trail_blitter_if.sv | 37 +++
 rtl/trail_blitter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trail_blitter_if.sv
// ---------------------------------------------------------------------------
// trail_blitter_if
// Memory-side bus of the trail blitter: a read port into the trail sprite ROM
// (one-cycle read latency) and a write port into the frame buffer.
//   rom_addr  : sprite ROM word address      (blitter -> ROM)
//   rom_data  : sprite ROM read data         (ROM -> blitter)
//   fb_addr   : frame-buffer word address    (blitter -> frame buffer)
//   fb_data   : frame-buffer write data      (blitter -> frame buffer)
//   fb_we     : frame-buffer write enable    (blitter -> frame buffer)
// The master modport is the blitter side; the slave modport is the memory side.
// ---------------------------------------------------------------------------
interface trail_blitter_if #(
    parameter int ADDR_W = 20,
    parameter int ROM_AW = 7
);
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;
    logic              fb_we;

    modport master (
        output rom_addr,
        output fb_addr,
        output fb_data,
        output fb_we,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  fb_addr,
        input  fb_data,
        input  fb_we,
        output rom_data
    );
endinterface

// File: rtl/trail_blitter.sv
// ---------------------------------------------------------------------------
// trail_blitter
// Watches the light-cycle positions of NUM_PLAYERS players and, whenever a
// player moves, copies a SPRITE_WORDS-word trail sprite (straight vertical,
// straight horizontal or corner) from the sprite ROM into the frame buffer at
// the player's grid position. One job per player can be queued; a newer move
// replaces a queued one and raises that player's sticky overrun flag.
//
// Ports
//   Clk, Reset   : clock, synchronous active-high reset
//   Game_State   : blitter runs only while this equals 3'b010
//   P_X, P_Y     : packed per-player grid coordinates, player 0 in the LSBs
//   P_dir        : packed per-player direction (00/01 vertical, 10/11 horiz.)
//   bus          : sprite ROM read port and frame-buffer write port
//   busy         : high whenever the sequencer is not idle
//   overrun      : sticky per-player "queued job was replaced" flags
// ---------------------------------------------------------------------------
module trail_blitter #(
    parameter int NUM_PLAYERS  = 2,
    parameter int COORD_W      = 8,
    parameter int SPRITE_WORDS = 16,
    parameter int ADDR_W       = 20,
    parameter int ROW_WORDS    = 1280,
    parameter int PIX_W        = 2,
    parameter int ORIGIN       = 0
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [2:0]                     Game_State,
    input  logic [NUM_PLAYERS*COORD_W-1:0] P_X,
    input  logic [NUM_PLAYERS*COORD_W-1:0] P_Y,
    input  logic [NUM_PLAYERS*2-1:0]       P_dir,
    trail_blitter_if.master                bus,
    output logic                           busy,
    output logic [NUM_PLAYERS-1:0]         overrun
);

    localparam int ROM_AW = $clog2(NUM_PLAYERS*3*SPRITE_WORDS);
    localparam int CNT_W  = (SPRITE_WORDS > 1) ? $clog2(SPRITE_WORDS) : 1;
    localparam int PTR_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [2:0] GS_PLAY = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_LOAD = 3'd2,
        S_COPY = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic active;
    assign active = (Game_State == GS_PLAY);

    // primed_q is set when the previous cycle was active; the first active
    // cycle only loads the "old" position registers.
    logic primed_q, primed_d;

    logic [NUM_PLAYERS*COORD_W-1:0] old_x_q, old_x_d;
    logic [NUM_PLAYERS*COORD_W-1:0] old_y_q, old_y_d;
    logic [NUM_PLAYERS*2-1:0]       old_dir_q, old_dir_d;

    // Per-player queued job
    logic [NUM_PLAYERS-1:0]              pend_q, pend_d;
    logic [NUM_PLAYERS-1:0][1:0]         pkind_q, pkind_d;
    logic [NUM_PLAYERS-1:0][COORD_W-1:0] px_q, px_d;
    logic [NUM_PLAYERS-1:0][COORD_W-1:0] py_q, py_d;
    logic [NUM_PLAYERS-1:0]              ovr_q, ovr_d;

    // Job being copied
    logic [PTR_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ROM_AW-1:0] spr_q, spr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  rr_q, rr_d;

    // Output hold registers: the bus keeps its last address/data when idle
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [15:0]       fb_data_q, fb_data_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

    // Per-player move detection and classification
    logic [NUM_PLAYERS-1:0][COORD_W-1:0] cur_x, cur_y, prev_x, prev_y;
    logic [NUM_PLAYERS-1:0][1:0]         cur_dir, prev_dir;
    logic [NUM_PLAYERS-1:0]              move;
    logic [NUM_PLAYERS-1:0][1:0]         kind_new;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            assign cur_x[gi]    = P_X[gi*COORD_W +: COORD_W];
            assign cur_y[gi]    = P_Y[gi*COORD_W +: COORD_W];
            assign cur_dir[gi]  = P_dir[gi*2 +: 2];
            assign prev_x[gi]   = old_x_q[gi*COORD_W +: COORD_W];
            assign prev_y[gi]   = old_y_q[gi*COORD_W +: COORD_W];
            assign prev_dir[gi] = old_dir_q[gi*2 +: 2];

            assign move[gi] = active && primed_q &&
                              ((cur_x[gi] != prev_x[gi]) || (cur_y[gi] != prev_y[gi]));

            // 2 = corner, 1 = vertical, 0 = horizontal
            assign kind_new[gi] = (cur_dir[gi] != prev_dir[gi]) ? 2'd2 :
                                  (cur_dir[gi][1] == 1'b0)      ? 2'd1 : 2'd0;
        end
    endgenerate

    // Round-robin arbiter: first pending player at or after rr_q
    logic             arb_found;
    logic [PTR_W-1:0] arb_sel;
    int               idx;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_PLAYERS) begin
                idx = idx - NUM_PLAYERS;
            end
            if (!arb_found && pend_q[PTR_W'(idx)]) begin
                arb_found = 1'b1;
                arb_sel   = PTR_W'(idx);
            end
        end
    end

    logic [NUM_PLAYERS-1:0] take;

    always_comb begin
        take = '0;
        if (state_q == S_ARB && arb_found) begin
            take[arb_sel] = 1'b1;
        end
    end

    // Frame-buffer and sprite base addresses for the job being selected
    logic [ADDR_W-1:0] sel_x_w, sel_y_w, base_calc;
    logic [ROM_AW-1:0] spr_calc;

    always_comb begin
        sel_x_w   = ADDR_W'(px_q[arb_sel]);
        sel_y_w   = ADDR_W'(py_q[arb_sel]);
        base_calc = (sel_x_w + ADDR_W'(ORIGIN)) * ADDR_W'(PIX_W)
                  + (sel_y_w + ADDR_W'(ORIGIN)) * ADDR_W'(ROW_WORDS);
        spr_calc  = ROM_AW'((int'(arb_sel) * 3 + int'(pkind_q[arb_sel])) * SPRITE_WORDS);
    end

    logic cnt_last;
    assign cnt_last = (cnt_q == CNT_W'(SPRITE_WORDS - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|pend_q) state_d = S_ARB;
            S_ARB:   state_d = arb_found ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_COPY;
            S_COPY:  if (cnt_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Leaving play aborts whatever is in flight
        if (!active) begin
            state_d = S_IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy         = (state_q != S_IDLE);
        overrun      = ovr_q;
        bus.fb_we    = (state_q == S_COPY);
        bus.fb_addr  = fb_addr_q;
        bus.fb_data  = fb_data_q;
        bus.rom_addr = rom_addr_q;
        case (state_q)
            S_LOAD: begin
                bus.rom_addr = spr_q;
            end
            S_COPY: begin
                bus.fb_addr  = base_q + ADDR_W'(cnt_q);
                bus.fb_data  = bus.rom_data;
                // Prefetch the next word so it arrives with the next write
                bus.rom_addr = spr_q + ROM_AW'(cnt_q) + ROM_AW'(1);
            end
            default: ;
        endcase
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        primed_d   = active;
        old_x_d    = active ? P_X   : old_x_q;
        old_y_d    = active ? P_Y   : old_y_q;
        old_dir_d  = active ? P_dir : old_dir_q;

        pend_d     = pend_q;
        pkind_d    = pkind_q;
        px_d       = px_q;
        py_d       = py_q;
        ovr_d      = ovr_q;

        sel_d      = sel_q;
        base_d     = base_q;
        spr_d      = spr_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;

        fb_addr_d  = bus.fb_addr;
        fb_data_d  = bus.fb_data;
        rom_addr_d = bus.rom_addr;

        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (!active) begin
                pend_d[p] = 1'b0;
            end else if (move[p]) begin
                // A move arriving while the same player is being taken in ARB
                // re-queues with the new data and does not count as overrun.
                if (pend_q[p] && !take[p]) begin
                    ovr_d[p] = 1'b1;
                end
                pend_d[p]  = 1'b1;
                pkind_d[p] = kind_new[p];
                px_d[p]    = cur_x[p];
                py_d[p]    = cur_y[p];
            end else if (take[p]) begin
                pend_d[p] = 1'b0;
            end
        end

        if (state_q == S_ARB && arb_found) begin
            sel_d  = arb_sel;
            base_d = base_calc;
            spr_d  = spr_calc;
        end

        if (state_q == S_LOAD) begin
            cnt_d = '0;
        end else if (state_q == S_COPY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_q == S_DONE) begin
            if (int'(sel_q) == NUM_PLAYERS - 1) begin
                rr_d = '0;
            end else begin
                rr_d = sel_q + PTR_W'(1);
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            primed_q   <= 1'b0;
            old_x_q    <= '0;
            old_y_q    <= '0;
            old_dir_q  <= '0;
            pend_q     <= '0;
            pkind_q    <= '0;
            px_q       <= '0;
            py_q       <= '0;
            ovr_q      <= '0;
            sel_q      <= '0;
            base_q     <= '0;
            spr_q      <= '0;
            cnt_q      <= '0;
            rr_q       <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            rom_addr_q <= '0;
        end else begin
            primed_q   <= primed_d;
            old_x_q    <= old_x_d;
            old_y_q    <= old_y_d;
            old_dir_q  <= old_dir_d;
            pend_q     <= pend_d;
            pkind_q    <= pkind_d;
            px_q       <= px_d;
            py_q       <= py_d;
            ovr_q      <= ovr_d;
            sel_q      <= sel_d;
            base_q     <= base_d;
            spr_q      <= spr_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            rom_addr_q <= rom_addr_d;
        end
    end

endmodule
